// File: rtl/apb_slave_regfile_pkg.sv
// apb_slave_regfile_pkg: shared APB/AHB bus defines and regfile FSM state encodings
`ifndef APB_DEFINES_SVH
`define APB_DEFINES_SVH
`define PADDR_WIDTH 32
`define APB_DATA_WIDTH 32
`define IDLE 2'b00
`define BUSY 2'b01
`define APB_S_IDLE 1'b0
`define APB_S_ACCESS 1'b1
`endif

package apb_slave_regfile_pkg;
  localparam logic [0:0] S_IDLE = `APB_S_IDLE;
  localparam logic [0:0] S_ACCESS = `APB_S_ACCESS;
endpackage

// File: rtl/apb_slave_regfile.sv
// apb_slave_regfile: APB responder with NUM_REGS word registers, wait states and decode errors
module apb_slave_regfile
  import apb_slave_regfile_pkg::*;
#(
  parameter int NUM_REGS = 8,
  parameter int WAIT_CYCLES = 1,
  parameter logic [63:0] RO_MASK = 64'h80,
  parameter logic [31:0] ID_VALUE = 32'hA5B2_0001
) (
  input  logic                       pclk,
  input  logic                       preset,
  input  logic                       psel_x,
  input  logic                       penable,
  input  logic                       pwrite,
  input  logic [`PADDR_WIDTH-1:0]    paddr,
  input  logic [`APB_DATA_WIDTH-1:0] pwdata,
  output logic [`APB_DATA_WIDTH-1:0] prdata_x,
  output logic                       pready_x,
  output logic                       pslverr_x,
  output logic [31:0]                ctrl_q
);
  localparam int IW = $clog2(NUM_REGS);
  logic [0:0] state;
  logic [3:0] cnt;
  logic w_q, err_q;
  logic [IW-1:0] idx_q;
  logic [31:0] wdata_q;
  logic [31:0] regs [NUM_REGS];
  logic [IW-1:0] idx;
  logic dec_err;
  logic [31:0] rd;
  // any address bit above the register window counts as out of range
  assign idx = paddr[2 +: IW];
  assign dec_err = (|paddr[1:0]) || (|(paddr >> (IW + 2))) || (pwrite && RO_MASK[idx]);
  assign rd = RO_MASK[idx_q] ? ID_VALUE : regs[idx_q];
  assign pready_x = (state == S_ACCESS) && (cnt == 4'd0);
  assign pslverr_x = pready_x && err_q;
  assign prdata_x = (pready_x && !w_q && !err_q) ? rd : '0;
  assign ctrl_q = regs[0];
  always_ff @(posedge pclk) begin
    if (preset) begin
      state <= S_IDLE;
      cnt <= '0;
      w_q <= 1'b0;
      err_q <= 1'b0;
      idx_q <= '0;
      wdata_q <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (state == S_IDLE) begin
      if (psel_x && !penable) begin
        state <= S_ACCESS;
        cnt <= 4'(WAIT_CYCLES);
        w_q <= pwrite;
        err_q <= dec_err;
        idx_q <= idx;
        wdata_q <= pwdata;
      end
    end else if (!psel_x) begin
      state <= S_IDLE;
    end else if (penable) begin
      if (cnt != 4'd0) cnt <= cnt - 4'd1;
      else begin
        state <= S_IDLE;
        if (w_q && !err_q) regs[idx_q] <= wdata_q;
      end
    end
  end
endmodule

// File: tb/tb_apb_slave_regfile.sv
// tb_apb_slave_regfile: scoreboard bench over three slaves with 1, 0 and 3 wait states
module tb_apb_slave_regfile;
  logic clk = 1'b0;
  logic preset, penable, pwrite;
  logic [2:0] psel;
  logic [31:0] paddr, pwdata;
  logic [31:0] prdata [3];
  logic [31:0] ctrl [3];
  logic pready [3];
  logic pslverr [3];
  int waits [3] = '{1, 0, 3};
  int n_cmp = 0, n_bad = 0;
  typedef struct {logic [31:0] rd; logic err; int lat;} exp_t;
  exp_t sb [$];

  always #5 clk = ~clk;

  apb_slave_regfile #(.WAIT_CYCLES(1)) u0 (.pclk(clk), .preset(preset), .psel_x(psel[0]), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .prdata_x(prdata[0]), .pready_x(pready[0]),
    .pslverr_x(pslverr[0]), .ctrl_q(ctrl[0]));
  apb_slave_regfile #(.WAIT_CYCLES(0)) u1 (.pclk(clk), .preset(preset), .psel_x(psel[1]), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .prdata_x(prdata[1]), .pready_x(pready[1]),
    .pslverr_x(pslverr[1]), .ctrl_q(ctrl[1]));
  apb_slave_regfile #(.WAIT_CYCLES(3)) u2 (.pclk(clk), .preset(preset), .psel_x(psel[2]), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .prdata_x(prdata[2]), .pready_x(pready[2]),
    .pslverr_x(pslverr[2]), .ctrl_q(ctrl[2]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setup(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd);
    psel = '0;
    psel[d] = 1'b1;
    penable = 1'b0;
    pwrite = w;
    paddr = a;
    pwdata = wd;
  endtask

  task automatic xfer(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd,
                      input logic [31:0] rd, input logic err, input bit b2b);
    exp_t e;
    bit done = 0;
    setup(d, w, a, wd);
    sb.push_back('{rd, err, waits[d] + 1});
    tick();
    penable = 1'b1;
    for (int n = 1; n <= 40 && !done; n++) begin
      if (pready[d]) begin
        e = sb.pop_front();
        check($sformatf("d%0d %s %h rdata", d, w ? "wr" : "rd", a), prdata[d], e.rd);
        check($sformatf("d%0d %s %h err", d, w ? "wr" : "rd", a), 32'(pslverr[d]), 32'(e.err));
        check($sformatf("d%0d %s %h latency", d, w ? "wr" : "rd", a), n, e.lat);
        done = 1;
      end
      tick();
    end
    if (!done) begin
      void'(sb.pop_front());
      check($sformatf("d%0d %h timeout", d, a), 0, 1);
    end
    if (!b2b) begin
      psel = '0;
      penable = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit seen;
    preset = 1'b1;
    psel = '0;
    penable = 1'b0;
    pwrite = 1'b0;
    paddr = '0;
    pwdata = '0;
    repeat (2) tick();
    check("rst pready", 32'(pready[0]), 0);
    check("rst pslverr", 32'(pslverr[0]), 0);
    check("rst prdata", prdata[0], 0);
    check("rst ctrl_q", ctrl[0], 0);
    preset = 1'b0;
    tick();
    xfer(0, 1, 32'h0, 32'hDEAD_BEEF, 0, 0, 0);
    check("ctrl_q after write", ctrl[0], 32'hDEAD_BEEF);
    xfer(0, 0, 32'h0, 0, 32'hDEAD_BEEF, 0, 0);
    xfer(0, 0, 32'h1C, 0, 32'hA5B2_0001, 0, 0);
    xfer(0, 1, 32'h1C, 32'h1234, 0, 1, 0);
    xfer(0, 0, 32'h1C, 0, 32'hA5B2_0001, 0, 0);
    xfer(0, 0, 32'h20, 0, 0, 1, 0);
    xfer(0, 0, 32'h1000_0000, 0, 0, 1, 0);
    xfer(0, 1, 32'h06, 32'hFFFF_FFFF, 0, 1, 0);
    xfer(0, 0, 32'h4, 0, 0, 0, 0);
    check("ctrl_q kept", ctrl[0], 32'hDEAD_BEEF);
    // zero-wait slave, back-to-back with no idle cycle between transfers
    xfer(1, 1, 32'h4, 32'h1111_0004, 0, 0, 1);
    xfer(1, 1, 32'h8, 32'h2222_0008, 0, 0, 1);
    xfer(1, 0, 32'h4, 0, 32'h1111_0004, 0, 1);
    xfer(1, 0, 32'h8, 0, 32'h2222_0008, 0, 0);
    tick();
    setup(2, 1, 32'h4, 32'h5555);
    tick();
    penable = 1'b1;
    tick();
    psel = '0;
    penable = 1'b0;
    tick();
    check("abort pready", 32'(pready[2]), 0);
    xfer(2, 0, 32'h4, 0, 0, 0, 0);
    xfer(2, 1, 32'h0, 32'hCAFE, 0, 0, 0);
    check("d2 ctrl_q", ctrl[2], 32'hCAFE);
    // reset lands on the would-be commit edge of a write
    setup(2, 1, 32'h4, 32'h99);
    tick();
    penable = 1'b1;
    seen = 0;
    for (int n = 0; n < 40 && !seen; n++) begin
      if (pready[2]) seen = 1;
      else tick();
    end
    check("reset-abort reached ready", 32'(seen), 1);
    preset = 1'b1;
    tick();
    check("mid rst pready", 32'(pready[2]), 0);
    check("mid rst pslverr", 32'(pslverr[2]), 0);
    check("mid rst prdata", prdata[2], 0);
    check("mid rst ctrl_q", ctrl[2], 0);
    preset = 1'b0;
    psel = '0;
    penable = 1'b0;
    tick();
    xfer(2, 0, 32'h4, 0, 0, 0, 0);
    check("scoreboard empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
